// File: rtl/byte_unstuffer_pkg.sv
// Shared JPEG marker constants and unstuffer FSM state encoding.
package byte_unstuffer_pkg;

  localparam logic [7:0] MARKER_PFX = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic [7:0] RST_FIRST  = 8'hD0;
  localparam logic [7:0] RST_LAST   = 8'hD7;
  localparam logic [7:0] EOI_CODE   = 8'hD9;
  localparam logic [7:0] PAD_BYTE   = 8'hFF;

  typedef enum logic [1:0] {
    NORM    = 2'd0,
    SEEN_FF = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic is_rst_marker(input logic [7:0] b);
    return (b >= RST_FIRST) && (b <= RST_LAST);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word assembly with 0xFF-padded flush; the held word leaves
// when take is raised, and a byte appended in that same cycle starts the next word.
module word_packer
  import byte_unstuffer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_dat,
  input  logic         append,
  input  logic         flush,
  input  logic         take,
  output logic [W-1:0] word_dat,
  output logic         full
);

  localparam int N  = W / 8;
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]  asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_cnt = take ? '0 : cnt_q;
    asm_d    = take ? '0 : asm_q;
    cnt_d    = base_cnt;
    if (append) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == base_cnt) asm_d[W-1-8*i -: 8] = byte_dat;
      end
      cnt_d = base_cnt + CW'(1);
    end
    // A flushed partial word is padded and marked full so it drains like any other word.
    if (flush && (base_cnt != '0)) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) >= base_cnt) asm_d[W-1-8*i -: 8] = PAD_BYTE;
      end
      cnt_d = CW'(N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_dat = asm_q;
  assign full     = (cnt_q == CW'(N));

endmodule

// File: rtl/byte_unstuffer.sv
// JPEG scan byte unstuffer: strips 0xFF00 stuffing and fill bytes, flushes on markers,
// packs bytes into W-bit words with a single holding register on a valid/request handshake.
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif

module byte_unstuffer
  import byte_unstuffer_pkg::*;
#(
  parameter int W = `IN_BUS_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  input  logic         request,
  output logic         marker_pulse,
  output logic [7:0]   marker_code,
  output logic         eoi,
  output logic         err
);

  state_t       state_q, state_d;
  logic         accept, append, flush, mark, set_eoi, set_err;
  logic [7:0]   app_byte;
  logic         full, take, consume, hold_vld;
  logic [W-1:0] hold_dat, word;

  assign consume    = hold_vld && request;
  assign take       = full && (!hold_vld || consume);
  assign byte_ready = (state_q != DONE) && !(full && !take);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d  = state_q;
    append   = 1'b0;
    app_byte = byte_in;
    flush    = 1'b0;
    mark     = 1'b0;
    set_eoi  = 1'b0;
    set_err  = 1'b0;
    if (accept) begin
      case (state_q)
        NORM: begin
          if (byte_in == MARKER_PFX) state_d = SEEN_FF;
          else                       append  = 1'b1;
        end
        SEEN_FF: begin
          if (byte_in == STUFF_BYTE) begin
            append   = 1'b1;
            app_byte = MARKER_PFX;
            state_d  = NORM;
          end else if (byte_in == MARKER_PFX) begin
            state_d = SEEN_FF;
          end else begin
            mark  = 1'b1;
            flush = 1'b1;
            if (byte_in == EOI_CODE) begin
              set_eoi = 1'b1;
              state_d = DONE;
            end else begin
              set_err = !is_rst_marker(byte_in);
              state_d = NORM;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  word_packer #(.W(W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .byte_dat (app_byte),
    .append   (append),
    .flush    (flush),
    .take     (take),
    .word_dat (word),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORM;
      hold_vld     <= 1'b0;
      hold_dat     <= '0;
      marker_pulse <= 1'b0;
      marker_code  <= 8'h00;
      eoi          <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      marker_pulse <= mark;
      if (mark)    marker_code <= byte_in;
      if (set_eoi) eoi <= 1'b1;
      if (set_err) err <= 1'b1;
      // Load has priority over consume so a drain and refill in one cycle leaves no bubble.
      if (take) begin
        hold_vld <= 1'b1;
        hold_dat <= word;
      end else if (consume) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign valid_out = hold_vld;
  assign data_out  = hold_dat;

endmodule

// File: tb/tb_byte_unstuffer.sv
// Scoreboard bench for byte_unstuffer: directed byte streams, expected words queued, monitor compares.
module tb_byte_unstuffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_valid = 1'b0;
  logic         byte_ready;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         request = 1'b1;
  logic         marker_pulse;
  logic [7:0]   marker_code;
  logic         eoi;
  logic         err;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [W-1:0] expq[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_dat = '0;

  always #5 clk = ~clk;

  byte_unstuffer #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .request      (request),
    .marker_pulse (marker_pulse),
    .marker_code  (marker_code),
    .eoi          (eoi),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected word per transfer, checks hold stability, counts marker pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!valid_out || data_out !== prev_dat) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h",
                   valid_out, data_out, prev_dat);
        end
      end
      if (valid_out && request) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got 0x%08h, expected no word", data_out);
        end else begin
          logic [W-1:0] e;
          e = expq.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL word: got 0x%08h, expected 0x%08h", data_out, e);
          end
        end
      end
      if (marker_pulse) mcount++;
      prev_stall = valid_out && !request;
      prev_dat   = data_out;
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got byte_ready=0 for byte 0x%02h, expected 1", b);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid_out"},    32'(valid_out),    32'h0);
    chk({tag, "_data_out"},     data_out,          32'h0);
    chk({tag, "_marker_pulse"}, 32'(marker_pulse), 32'h0);
    chk({tag, "_marker_code"},  32'(marker_code),  32'h0);
    chk({tag, "_eoi"},          32'(eoi),          32'h0);
    chk({tag, "_err"},          32'(err),          32'h0);
    chk({tag, "_byte_ready"},   32'(byte_ready),   32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int m0;
    logic [7:0] stuff_v[9];
    stuff_v = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    idle(1);

    // Stuffed 0xFF00 yields a data 0xFF; second word starts at 0x78.
    expq.push_back(32'h1234FF56);
    expq.push_back(32'h789ABCDE);
    foreach (stuff_v[i]) send(stuff_v[i]);
    idle(6);
    chk("stuff_drained", 32'(expq.size()), 32'h0);

    // RST marker flushes a partial word padded with 0xFF and returns to NORM.
    m0 = mcount;
    expq.push_back(32'hABCDFFFF);
    send(8'hAB); send(8'hCD); send(8'hFF); send(8'hD3);
    idle(4);
    chk("rst_marker_pulses", 32'(mcount - m0), 32'h1);
    chk("rst_marker_code",   32'(marker_code), 32'hD3);
    chk("rst_marker_err",    32'(err),         32'h0);
    expq.push_back(32'h01020304);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(6);
    chk("rst_norm_drained", 32'(expq.size()), 32'h0);

    // Backpressure: holding and assembly registers fill, then ready drops.
    request = 1'b0;
    expq.push_back(32'h00010203);
    expq.push_back(32'h04050607);
    expq.push_back(32'h08090A0B);
    for (int i = 0; i < 8; i++) send(8'(i));
    repeat (4) @(negedge clk);
    chk("bp_byte_ready", 32'(byte_ready), 32'h0);
    chk("bp_valid_out",  32'(valid_out),  32'h1);
    chk("bp_data_out",   data_out,        32'h00010203);
    @(posedge clk);
    #1 request = 1'b1;
    for (int i = 8; i < 12; i++) send(8'(i));
    idle(6);
    chk("bp_drained", 32'(expq.size()), 32'h0);

    // EOI: fill byte ignored, partial word flushed, input closed.
    m0 = mcount;
    expq.push_back(32'h11FFFFFF);
    send(8'h11); send(8'hFF); send(8'hFF); send(8'hD9);
    idle(5);
    chk("eoi_flag",        32'(eoi),           32'h1);
    chk("eoi_marker_code", 32'(marker_code),   32'hD9);
    chk("eoi_pulses",      32'(mcount - m0),   32'h1);
    chk("eoi_err",         32'(err),           32'h0);
    byte_in = 8'h22;
    byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("eoi_byte_ready", 32'(byte_ready), 32'h0);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
    chk("eoi_drained", 32'(expq.size()), 32'h0);

    // Reset clears sticky flags; unknown marker sets err without emitting a word.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset2");
    idle(1);
    m0 = mcount;
    send(8'hFF); send(8'hC4);
    idle(4);
    chk("unk_err",         32'(err),         32'h1);
    chk("unk_marker_code", 32'(marker_code), 32'hC4);
    chk("unk_eoi",         32'(eoi),         32'h0);
    chk("unk_pulses",      32'(mcount - m0), 32'h1);

    // Mid-word reset discards partial data with no flush.
    send(8'h55); send(8'h66);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset3");
    m0 = mcount;
    repeat (8) @(negedge clk);
    chk("rst_no_word",   32'(valid_out),     32'h0);
    chk("rst_no_marker", 32'(mcount - m0),   32'h0);
    chk("final_queue",   32'(expq.size()),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
